// File: rtl/mesm6_memory.sv
// ============================================================================
// Module   : mesm6_memory
// Purpose  : Word memory responder for the MESM-6 core. Serves the
//            instruction bus (ibus_*) and the data bus (dbus_*) from one
//            single-port RAM of 48-bit words. It inserts programmable wait
//            states and answers each request with a one-cycle done pulse.
//            When a fetch and a data access arrive together, both are
//            performed (data first) and both done pulses rise in the same
//            cycle.
// Ports    : clk, reset (async, active-high)
//            ibus_fetch / ibus_addr  -> ibus_input / ibus_done
//            dbus_read / dbus_write / dbus_addr / dbus_output
//                                    -> dbus_input / dbus_done
// Params   : ADDR_BITS   - RAM depth is 2^ADDR_BITS words (addresses wrap)
//            WAIT_STATES - extra cycles before each RAM access (0..7)
//            MEM_INIT    - retained for interface compatibility
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesm6_memory #(
    parameter int ADDR_BITS   = 15,
    parameter int WAIT_STATES = 0,
    parameter     MEM_INIT    = ""
) (
    input  logic        clk,
    input  logic        reset,
    // instruction bus
    input  logic        ibus_fetch,
    input  logic [14:0] ibus_addr,
    output logic [47:0] ibus_input,
    output logic        ibus_done,
    // data bus
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [14:0] dbus_addr,
    input  logic [47:0] dbus_output,
    output logic [47:0] dbus_input,
    output logic        dbus_done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT1    = 2'd1,
        S_ACC2WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // The first access happens at the edge where the counter reads 0. The
    // counter is loaded at the request edge E0, one edge before counting
    // starts, so the first-access delay is loaded as WAIT_STATES-1. The second
    // access (fetch) is separated from the first by a full WAIT_STATES+1
    // edges, so it is loaded with WAIT_STATES itself.
    localparam logic [2:0] c_WAIT_FULL  = 3'(WAIT_STATES);
    localparam logic [2:0] c_WAIT_FIRST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
    localparam bit         c_NO_WAIT    = (WAIT_STATES == 0);

    state_t                 r_state;
    logic [2:0]             r_cnt;
    logic                   r_pend_d;
    logic                   r_pend_i;
    logic                   r_wr;
    logic [ADDR_BITS-1:0]   r_iaddr;
    logic [ADDR_BITS-1:0]   r_daddr;
    logic [47:0]            r_wdata;

    logic [47:0]            r_mem [0:(1<<ADDR_BITS)-1];

    logic                   w_idle;
    logic                   w_req;
    logic                   w_pend_d;
    logic                   w_pend_i;
    logic                   w_wr;
    logic [ADDR_BITS-1:0]   w_iaddr;
    logic [ADDR_BITS-1:0]   w_daddr;
    logic [47:0]            w_wdata;
    logic                   w_first;
    logic                   w_second;
    logic [ADDR_BITS-1:0]   w_ram_addr;
    logic                   w_ram_we;
    logic [47:0]            w_rdata;

    // In IDLE with WAIT_STATES=0 the first access happens at the request
    // edge itself, before anything has been latched, so the access operands
    // come straight from the bus in that state and from the latches otherwise.
    assign w_idle   = (r_state == S_IDLE);
    assign w_req    = ibus_fetch | dbus_read | dbus_write;
    assign w_pend_d = w_idle ? (dbus_read | dbus_write) : r_pend_d;
    assign w_pend_i = w_idle ? ibus_fetch               : r_pend_i;
    assign w_wr     = w_idle ? dbus_write               : r_wr;
    assign w_iaddr  = w_idle ? ibus_addr[ADDR_BITS-1:0] : r_iaddr;
    assign w_daddr  = w_idle ? dbus_addr[ADDR_BITS-1:0] : r_daddr;
    assign w_wdata  = w_idle ? dbus_output              : r_wdata;

    assign w_first  = (w_idle && w_req && c_NO_WAIT) ||
                      (r_state == S_WAIT1 && r_cnt == 3'd0);
    assign w_second = (r_state == S_ACC2WAIT) && (r_cnt == 3'd0);

    // Data port has priority for the first access; the second access is
    // always the pending fetch.
    assign w_ram_addr = w_first ? (w_pend_d ? w_daddr : w_iaddr) : r_iaddr;
    // Write wins over a simultaneous read. Gated by reset so that a write
    // whose commit edge falls inside reset is dropped.
    assign w_ram_we   = w_first && w_pend_d && w_wr && !reset;
    assign w_rdata    = r_mem[w_ram_addr];

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_pend_d   <= 1'b0;
            r_pend_i   <= 1'b0;
            r_wr       <= 1'b0;
            r_iaddr    <= '0;
            r_daddr    <= '0;
            r_wdata    <= '0;
            ibus_done  <= 1'b0;
            dbus_done  <= 1'b0;
            ibus_input <= '0;
            dbus_input <= '0;
        end else begin
            // done is only ever set on the edge entering DONE, so clearing it
            // every other edge makes it exactly one cycle wide.
            ibus_done <= 1'b0;
            dbus_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_iaddr  <= ibus_addr[ADDR_BITS-1:0];
                        r_daddr  <= dbus_addr[ADDR_BITS-1:0];
                        r_wdata  <= dbus_output;
                        r_pend_d <= dbus_read | dbus_write;
                        r_pend_i <= ibus_fetch;
                        r_wr     <= dbus_write;
                        r_cnt    <= c_WAIT_FIRST;
                        r_state  <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_ACC2WAIT: begin
                    if (w_second) begin
                        ibus_input <= w_rdata;
                        ibus_done  <= 1'b1;
                        dbus_done  <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    // Requests seen here are the ones just served; ignore them.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // First access overrides the IDLE/WAIT1 transitions above.
            if (w_first) begin
                if (w_pend_d) begin
                    dbus_input <= w_wr ? w_wdata : w_rdata;
                end else begin
                    ibus_input <= w_rdata;
                end
                if (w_pend_d && w_pend_i) begin
                    r_cnt   <= c_WAIT_FULL;
                    r_state <= S_ACC2WAIT;
                end else begin
                    dbus_done <= w_pend_d;
                    ibus_done <= !w_pend_d;
                    r_state   <= S_DONE;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mesm6_memory.sv
// ============================================================================
// Module   : tb_mesm6_memory
// Purpose  : Directed self-checking bench for mesm6_memory. Four instances
//            with WAIT_STATES 0..3 share the request inputs; each step
//            checks the instance whose wait-state setting it targets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesm6_memory;

  logic        clk;
  logic        reset;
  logic        ibus_fetch;
  logic [14:0] ibus_addr;
  logic        dbus_read;
  logic        dbus_write;
  logic [14:0] dbus_addr;
  logic [47:0] dbus_output;

  logic [47:0] ib_in [4];
  logic        ib_dn [4];
  logic [47:0] db_in [4];
  logic        db_dn [4];

  int nchk;
  int nerr;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      mesm6_memory #(
        .ADDR_BITS   (15),
        .WAIT_STATES (g),
        .MEM_INIT    ("")
      ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .ibus_fetch  (ibus_fetch),
        .ibus_addr   (ibus_addr),
        .ibus_input  (ib_in[g]),
        .ibus_done   (ib_dn[g]),
        .dbus_read   (dbus_read),
        .dbus_write  (dbus_write),
        .dbus_addr   (dbus_addr),
        .dbus_output (dbus_output),
        .dbus_input  (db_in[g]),
        .dbus_done   (db_dn[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gap();
    repeat (20) @(negedge clk);
  endtask

  // Core-style transfer: drive at a negedge, hold until a done pulse from
  // instance w, drop the request, then confirm the pulse is one cycle wide.
  task automatic xfer(input int w, input logic f, input logic rd, input logic wr,
                      input logic [14:0] ia, input logic [14:0] da,
                      input logic [47:0] wd, input int lat, input string tag);
    int n;
    ibus_fetch  = f;
    ibus_addr   = ia;
    dbus_read   = rd;
    dbus_write  = wr;
    dbus_addr   = da;
    dbus_output = wd;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!(ib_dn[w] || db_dn[w]) && n < 40);
    check({tag, "_latency"}, 48'(n), 48'(lat));
    check({tag, "_ibus_done"}, {47'd0, ib_dn[w]}, {47'd0, f});
    check({tag, "_dbus_done"}, {47'd0, db_dn[w]}, {47'd0, rd | wr});
    ibus_fetch = 1'b0;
    dbus_read  = 1'b0;
    dbus_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_width"}, {46'd0, ib_dn[w], db_dn[w]}, 48'd0);
    gap();
  endtask

  initial begin
    logic [11:0] mask;
    nchk        = 0;
    nerr        = 0;
    reset       = 1'b1;
    ibus_fetch  = 1'b0;
    ibus_addr   = '0;
    dbus_read   = 1'b0;
    dbus_write  = 1'b0;
    dbus_addr   = '0;
    dbus_output = '0;
    repeat (2) @(negedge clk);

    // Reset state on the no-wait and longest-wait instances
    check("rst_ibus_done_w0",  {47'd0, ib_dn[0]}, 48'd0);
    check("rst_dbus_done_w0",  {47'd0, db_dn[0]}, 48'd0);
    check("rst_ibus_input_w0", ib_in[0], 48'd0);
    check("rst_dbus_input_w3", db_in[3], 48'd0);
    reset = 1'b0;
    @(negedge clk);

    // Preload through the data bus (all instances see these writes)
    xfer(0, 1'b0, 1'b0, 1'b1, 15'd0, 15'o100, 48'h123456789ABC, 1, "pre100");
    xfer(0, 1'b0, 1'b0, 1'b1, 15'd0, 15'd1,   48'h00000000000A, 1, "pre1");
    xfer(0, 1'b0, 1'b0, 1'b1, 15'd0, 15'd2,   48'h00000000000B, 1, "pre2");
    xfer(0, 1'b0, 1'b0, 1'b1, 15'd0, 15'd3,   48'h000000000333, 1, "pre3");
    xfer(0, 1'b0, 1'b0, 1'b1, 15'd0, 15'd5,   48'h000000005555, 1, "pre5");

    // Fetch, no wait states: one-cycle latency, data bus stays quiet
    xfer(0, 1'b1, 1'b0, 1'b0, 15'o100, 15'd0, 48'd0, 1, "fetch100");
    check("fetch100_data", ib_in[0], 48'h123456789ABC);

    // Write then read back at the top of a 12-bit range
    xfer(0, 1'b0, 1'b0, 1'b1, 15'd0, 15'o7777, 48'hFFFF00000001, 1, "wr7777");
    check("wr7777_echo", db_in[0], 48'hFFFF00000001);
    xfer(0, 1'b0, 1'b1, 1'b0, 15'd0, 15'o7777, 48'd0, 1, "rd7777");
    check("rd7777_data", db_in[0], 48'hFFFF00000001);

    // Dual fetch+read with two wait states: both done at latency 2+2*2
    xfer(2, 1'b1, 1'b1, 1'b0, 15'd1, 15'd2, 48'd0, 6, "dual_w2");
    check("dual_w2_ibus_data", ib_in[2], 48'h00000000000A);
    check("dual_w2_dbus_data", db_in[2], 48'h00000000000B);

    // Dual fetch+write to one address: write lands first, fetch sees it
    xfer(0, 1'b1, 1'b0, 1'b1, 15'd3, 15'd3, 48'hC0FFEE123456, 2, "dualwr_w0");
    check("dualwr_w0_ibus_data", ib_in[0], 48'hC0FFEE123456);
    check("dualwr_w0_dbus_data", db_in[0], 48'hC0FFEE123456);

    // Back-to-back reads held through done, one wait state: done every 3 cycles
    dbus_read = 1'b1;
    dbus_addr = 15'o7777;
    mask      = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      mask[i] = db_dn[1];
    end
    dbus_read = 1'b0;
    check("b2b_w1_done_pattern", {36'd0, mask}, 48'h492);
    check("b2b_w1_data", db_in[1], 48'hFFFF00000001);
    gap();

    // Reset in the middle of a three-wait-state write
    xfer(3, 1'b0, 1'b1, 1'b0, 15'd0, 15'd5, 48'd0, 4, "rd5_w3");
    check("rd5_w3_data", db_in[3], 48'h000000005555);
    dbus_write  = 1'b1;
    dbus_addr   = 15'd5;
    dbus_output = 48'h00000000DEAD;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset      = 1'b1;
    dbus_write = 1'b0;
    #1;
    check("rst_async_dbus_input", db_in[3], 48'd0);
    check("rst_async_ibus_input", ib_in[3], 48'd0);
    check("rst_async_done", {46'd0, ib_dn[3], db_dn[3]}, 48'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    gap();
    xfer(3, 1'b0, 1'b1, 1'b0, 15'd0, 15'd5, 48'd0, 4, "rd5_after_rst");
    check("rd5_after_rst_data", db_in[3], 48'h000000005555);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
